// File: rtl/exe_pkg.sv
// Shared definitions for the multi-cycle execute stage: ALU command codes,
// status flag bit positions and the controller state encoding.
package exe_pkg;

    // ALU command encoding carried on EXE_CMDIn
    typedef enum logic [3:0] {
        CMD_MOV = 4'b0001,
        CMD_MVN = 4'b1001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MUL = 4'b1010
    } exe_cmd_e;

    // Bit positions inside the {N,Z,C,V} status nibble
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Controller states: IDLE accepts work, RUN waits on the multiplier
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } exe_state_e;

endpackage

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
// done is asserted in the cycle whose step completes the product; product is
// the accumulator value after that step, so the caller can register it at the
// same edge the last step retires.
module mul_unit #(
    parameter int DATA_W   = 32,
    parameter int MUL_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              hold,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int STEPS = DATA_W / MUL_STEP;
    localparam int CNT_W = $clog2(STEPS + 1);

    if (DATA_W % MUL_STEP != 0) begin : g_bad_step
        $error("mul_unit: DATA_W must be a multiple of MUL_STEP");
    end

    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] mcand_r;
    logic [DATA_W-1:0] mplier_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              busy_r;
    logic [DATA_W-1:0] acc_s;
    logic              last_s;

    // Add the partial products for the next MUL_STEP multiplier bits
    always_comb begin
        acc_s = acc_r;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mplier_r[j]) begin
                acc_s = acc_s + (mcand_r << j);
            end else begin
                acc_s = acc_s;
            end
        end
    end

    assign last_s  = (cnt_r == CNT_W'(STEPS - 1));
    assign busy    = busy_r;
    assign done    = busy_r & last_s;
    assign product = acc_s;

    // Operand load, per-cycle step, abort and hold of the multiplier datapath
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
        end else if (hold) begin
            busy_r <= busy_r;
        end else if (start) begin
            acc_r    <= '0;
            mcand_r  <= a;
            mplier_r <= b;
            cnt_r    <= '0;
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            acc_r    <= acc_s;
            mcand_r  <= mcand_r << MUL_STEP;
            mplier_r <= mplier_r >> MUL_STEP;
            cnt_r    <= cnt_r + CNT_W'(1);
            busy_r   <= ~last_s;
        end else begin
            busy_r <= 1'b0;
        end
    end

endmodule

// File: rtl/exe_stage_mc.sv
// Execute stage with single-cycle ALU operations and a multi-cycle MUL.
// A MUL parks its side-band fields in pending registers and stalls the stage
// until the multiplier finishes; then all outputs are written together.
module exe_stage_mc
    import exe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MUL_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              stall_out,
    input  logic              freeze_in,
    input  logic              flush_in,
    input  logic              WB_ENIn,
    input  logic              MEM_R_ENIn,
    input  logic              MEM_W_ENIn,
    input  logic              SIn,
    input  logic              BIn,
    input  logic [3:0]        EXE_CMDIn,
    input  logic [3:0]        DestIn,
    input  logic [3:0]        statusIn,
    input  logic [DATA_W-1:0] PCIn,
    input  logic [DATA_W-1:0] Val1In,
    input  logic [DATA_W-1:0] Val2In,
    input  logic [DATA_W-1:0] Val_RmIn,
    input  logic [23:0]       Imm24In,
    output logic              out_valid,
    output logic              WB_ENOut,
    output logic              MEM_R_ENOut,
    output logic              MEM_W_ENOut,
    output logic              branchTakenOut,
    output logic [3:0]        DestOut,
    output logic [3:0]        statusOut,
    output logic [DATA_W-1:0] ALU_ResOut,
    output logic [DATA_W-1:0] Val_RmOut,
    output logic [DATA_W-1:0] branchAddressOut
);

    if (DATA_W < 8) begin : g_bad_width
        $error("exe_stage_mc: DATA_W must be at least 8");
    end
    if (DATA_W % MUL_STEP != 0) begin : g_bad_step
        $error("exe_stage_mc: DATA_W must be a multiple of MUL_STEP");
    end

    exe_state_e        state_r, state_s;
    exe_cmd_e          cmd_s;
    logic              accept_s, is_mul_s, mul_busy_s, mul_done_s;
    logic [DATA_W-1:0] mul_prod_s, add_b_s, res_s, br_s;
    logic [DATA_W:0]   sum_s;
    logic              cin_s, arith_s, known_s, ovf_s;
    logic [3:0]        flags_s, mul_flags_s;
    logic              p_wb_r, p_mr_r, p_mw_r, p_b_r, p_s_r;
    logic [3:0]        p_dest_r, p_st_r;
    logic [DATA_W-1:0] p_valrm_r, p_br_r;

    assign cmd_s     = exe_cmd_e'(EXE_CMDIn);
    assign stall_out = (state_r == ST_RUN);
    assign accept_s  = in_valid & ~stall_out & ~freeze_in & ~flush_in;
    assign is_mul_s  = (cmd_s == CMD_MUL);
    assign br_s      = PCIn + DATA_W'($signed({Imm24In, 2'b00}));

    mul_unit #(
        .DATA_W  (DATA_W),
        .MUL_STEP(MUL_STEP)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (accept_s & is_mul_s),
        .abort  (flush_in),
        .hold   (freeze_in),
        .a      (Val1In),
        .b      (Val2In),
        .busy   (mul_busy_s),
        .done   (mul_done_s),
        .product(mul_prod_s)
    );

    // Single-cycle ALU: shared adder for ADD/ADC/SUB/SBC plus logic ops and flags
    always_comb begin
        add_b_s = Val2In;
        cin_s   = 1'b0;
        arith_s = 1'b0;
        known_s = 1'b1;
        res_s   = '0;
        case (cmd_s)
            CMD_MOV: res_s = Val2In;
            CMD_MVN: res_s = ~Val2In;
            CMD_ADD: arith_s = 1'b1;
            CMD_ADC: begin arith_s = 1'b1; cin_s = statusIn[FLAG_C]; end
            CMD_SUB: begin arith_s = 1'b1; add_b_s = ~Val2In; cin_s = 1'b1; end
            CMD_SBC: begin arith_s = 1'b1; add_b_s = ~Val2In; cin_s = statusIn[FLAG_C]; end
            CMD_AND: res_s = Val1In & Val2In;
            CMD_ORR: res_s = Val1In | Val2In;
            CMD_EOR: res_s = Val1In ^ Val2In;
            CMD_MUL: res_s = '0;
            default: known_s = 1'b0;
        endcase
        sum_s = {1'b0, Val1In} + {1'b0, add_b_s} + {{DATA_W{1'b0}}, cin_s};
        if (arith_s) begin
            res_s = sum_s[DATA_W-1:0];
        end else begin
            res_s = res_s;
        end
        ovf_s   = (Val1In[DATA_W-1] == add_b_s[DATA_W-1]) && (sum_s[DATA_W-1] != Val1In[DATA_W-1]);
        flags_s = statusIn;
        if (SIn && known_s) begin
            flags_s[FLAG_N] = res_s[DATA_W-1];
            flags_s[FLAG_Z] = (res_s == '0);
            if (arith_s) begin
                flags_s[FLAG_C] = sum_s[DATA_W];
                flags_s[FLAG_V] = ovf_s;
            end else begin
                flags_s[FLAG_C] = statusIn[FLAG_C];
                flags_s[FLAG_V] = statusIn[FLAG_V];
            end
        end else begin
            flags_s = statusIn;
        end
    end

    // MUL flags: N,Z from the product, C,V from the status captured at accept
    always_comb begin
        if (p_s_r) begin
            mul_flags_s = {mul_prod_s[DATA_W-1], (mul_prod_s == '0), p_st_r[FLAG_C], p_st_r[FLAG_V]};
        end else begin
            mul_flags_s = p_st_r;
        end
    end

    // Next-state logic: flush forces IDLE, freeze holds, MUL accept enters RUN
    always_comb begin
        state_s = state_r;
        if (flush_in) begin
            state_s = ST_IDLE;
        end else if (freeze_in) begin
            state_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && is_mul_s) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (mul_done_s || !mul_busy_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Controller state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Output and pending-MUL registers with rst > flush > freeze > normal priority
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid        <= 1'b0;
            WB_ENOut         <= 1'b0;
            MEM_R_ENOut      <= 1'b0;
            MEM_W_ENOut      <= 1'b0;
            branchTakenOut   <= 1'b0;
            DestOut          <= 4'h0;
            statusOut        <= 4'h0;
            ALU_ResOut       <= '0;
            Val_RmOut        <= '0;
            branchAddressOut <= '0;
            p_wb_r           <= 1'b0;
            p_mr_r           <= 1'b0;
            p_mw_r           <= 1'b0;
            p_b_r            <= 1'b0;
            p_s_r            <= 1'b0;
            p_dest_r         <= 4'h0;
            p_st_r           <= 4'h0;
            p_valrm_r        <= '0;
            p_br_r           <= '0;
        end else if (flush_in) begin
            out_valid      <= 1'b0;
            WB_ENOut       <= 1'b0;
            MEM_R_ENOut    <= 1'b0;
            MEM_W_ENOut    <= 1'b0;
            branchTakenOut <= 1'b0;
        end else if (freeze_in) begin
            out_valid <= out_valid;
        end else if (accept_s && is_mul_s) begin
            out_valid      <= 1'b0;
            WB_ENOut       <= 1'b0;
            MEM_R_ENOut    <= 1'b0;
            MEM_W_ENOut    <= 1'b0;
            branchTakenOut <= 1'b0;
            p_wb_r         <= WB_ENIn;
            p_mr_r         <= MEM_R_ENIn;
            p_mw_r         <= MEM_W_ENIn;
            p_b_r          <= BIn;
            p_s_r          <= SIn;
            p_dest_r       <= DestIn;
            p_st_r         <= statusIn;
            p_valrm_r      <= Val_RmIn;
            p_br_r         <= br_s;
        end else if (accept_s) begin
            out_valid        <= 1'b1;
            WB_ENOut         <= WB_ENIn;
            MEM_R_ENOut      <= MEM_R_ENIn;
            MEM_W_ENOut      <= MEM_W_ENIn;
            branchTakenOut   <= BIn;
            DestOut          <= DestIn;
            statusOut        <= flags_s;
            ALU_ResOut       <= res_s;
            Val_RmOut        <= Val_RmIn;
            branchAddressOut <= br_s;
        end else if (stall_out && mul_done_s) begin
            out_valid        <= 1'b1;
            WB_ENOut         <= p_wb_r;
            MEM_R_ENOut      <= p_mr_r;
            MEM_W_ENOut      <= p_mw_r;
            branchTakenOut   <= p_b_r;
            DestOut          <= p_dest_r;
            statusOut        <= mul_flags_s;
            ALU_ResOut       <= mul_prod_s;
            Val_RmOut        <= p_valrm_r;
            branchAddressOut <= p_br_r;
        end else begin
            out_valid      <= 1'b0;
            WB_ENOut       <= 1'b0;
            MEM_R_ENOut    <= 1'b0;
            MEM_W_ENOut    <= 1'b0;
            branchTakenOut <= 1'b0;
        end
    end

endmodule
